// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
// Optional ROM_ARB_RR_EN selects round-robin instead of fixed IF priority.
package rom_arb_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 4;

    function automatic logic cnt_sat(input logic [CNT_W-1:0] c);
        return &c;
    endfunction

endpackage

// File: rtl/rom_arb_if.sv
// Requester/ROM bundle of the arbiter; slave = arbiter, master = SOPC side.
// Signal names keep the SOPC wiring names.
interface rom_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              ls_req_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;

    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  ls_req_i, ls_addr_i,
        input  rom_data_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        output rom_ce_o, rom_addr_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output ls_req_i, ls_addr_i,
        output rom_data_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        input  rom_ce_o, rom_addr_o
    );

endinterface

// File: rtl/rom_arb_starve_cnt.sv
// Saturating wait counter for the load port; force_o requests a forced grant.
// Clears on grant or when the request is withdrawn.
import rom_arb_pkg::*;

module rom_arb_starve_cnt #(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic gnt_i,
    output logic force_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!req_i || gnt_i) begin
            r_cnt <= '0;
        end else if (!cnt_sat(r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign force_o = (r_cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/rom_arbiter.sv
// Shares the instruction ROM between CPU fetch (IF) and load-side reads (LS).
// Define ROM_ARB_RR_EN for round-robin; default is IF priority + starvation cap.
import rom_arb_pkg::*;

module rom_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic     clk,
    input  logic     rst,
    rom_arb_if.slave bus
);

    logic              w_force;
    logic              w_ls_pref;
    logic              w_if_win;
    logic              w_ls_win;
    logic              w_grant;
    owner_e            w_owner;
    logic [ADDR_W-1:0] w_addr;

    logic              r_rvalid;
    owner_e            r_owner;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;

    rom_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .req_i   (bus.ls_req_i),
        .gnt_i   (w_ls_win),
        .force_o (w_force)
    );

`ifdef ROM_ARB_RR_EN
    owner_e r_rr_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_last <= OWN_LS;
        end else if (w_grant) begin
            r_rr_last <= w_owner;
        end
    end

    assign w_ls_pref = (r_rr_last == OWN_IF) | w_force;
`else
    assign w_ls_pref = w_force;
`endif

    // rst gates the grants so nothing leaks out while reset is held
    assign w_ls_win = rst & bus.ls_req_i & (~bus.if_req_i | w_ls_pref);
    assign w_if_win = rst & bus.if_req_i & ~w_ls_win;
    assign w_grant  = w_if_win | w_ls_win;
    assign w_owner  = w_ls_win ? OWN_LS : OWN_IF;

    always_comb begin
        w_addr = '0;
        unique case (1'b1)
            w_ls_win: w_addr = bus.ls_addr_i;
            w_if_win: w_addr = bus.if_addr_i;
            default:  w_addr = '0;
        endcase
    end

    // Per-port data registers so the idle port keeps its last word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rvalid   <= 1'b0;
            r_owner    <= OWN_IF;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
        end else begin
            r_rvalid <= w_grant;
            if (w_grant) begin
                r_owner <= w_owner;
            end
            if (w_if_win) begin
                r_if_rdata <= bus.rom_data_i;
            end
            if (w_ls_win) begin
                r_ls_rdata <= bus.rom_data_i;
            end
        end
    end

    assign bus.if_gnt_o    = w_if_win;
    assign bus.ls_gnt_o    = w_ls_win;
    assign bus.rom_ce_o    = w_grant;
    assign bus.rom_addr_o  = w_addr;
    assign bus.if_rvalid_o = r_rvalid & (r_owner == OWN_IF);
    assign bus.ls_rvalid_o = r_rvalid & (r_owner == OWN_LS);
    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.ls_rdata_o  = r_ls_rdata;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: random + directed traffic vs. a reference model.
// Build with +define+ROM_ARB_RR_EN to check the round-robin variant.
import rom_arb_pkg::*;

module tb_rom_arbiter;

    localparam int SMAX = STARVE_MAX_DEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rom_arb_if bus ();

    rom_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] + 16'h1357};
    endfunction

    assign bus.rom_data_i = rom_fn(bus.rom_addr_o);

    typedef struct {
        int          cyc;
        bit          ls;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    bit          in_reset = 1'b1;
    int          m_wait = 0;
    bit          m_last_ls = 1'b1;
    logic [31:0] last_if = '0;
    logic [31:0] last_ls = '0;
    logic [1:0]  exp_tab [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: who should win this cycle and what the ROM returns
    always @(negedge clk) begin
        bit          ifr, lsr, pref, win_if, win_ls;
        logic [31:0] a;
        if (in_reset) begin
            chk("rst_if_gnt", bus.if_gnt_o, 0);
            chk("rst_ls_gnt", bus.ls_gnt_o, 0);
            chk("rst_ce", bus.rom_ce_o, 0);
            chk("rst_addr", bus.rom_addr_o, 0);
            chk("rst_if_rvalid", bus.if_rvalid_o, 0);
            chk("rst_ls_rvalid", bus.ls_rvalid_o, 0);
            chk("rst_if_rdata", bus.if_rdata_o, 0);
            chk("rst_ls_rdata", bus.ls_rdata_o, 0);
        end else begin
            ifr  = bus.if_req_i;
            lsr  = bus.ls_req_i;
            pref = (m_wait >= SMAX);
`ifdef ROM_ARB_RR_EN
            if (!m_last_ls) pref = 1'b1;
`endif
            win_ls = lsr && (!ifr || pref);
            win_if = ifr && !win_ls;
            a = win_ls ? bus.ls_addr_i : (win_if ? bus.if_addr_i : 32'h0);
            chk("if_gnt", bus.if_gnt_o, win_if);
            chk("ls_gnt", bus.ls_gnt_o, win_ls);
            chk("rom_ce", bus.rom_ce_o, win_if | win_ls);
            chk("rom_addr", bus.rom_addr_o, a);
            if (win_if || win_ls) begin
                q.push_back('{cyc, win_ls, rom_fn(a)});
                m_last_ls = win_ls;
            end
            m_wait = (lsr && !win_ls) ? m_wait + 1 : 0;
        end
    end

    // Monitor: a response is due exactly one cycle after its grant
    always @(negedge clk) begin
        bit   eif, els;
        rsp_t e;
        if (!in_reset) begin
            eif = 1'b0;
            els = 1'b0;
            if (q.size() > 0 && q[0].cyc == cyc - 1) begin
                e = q.pop_front();
                if (e.ls) begin
                    els = 1'b1;
                    last_ls = e.data;
                end else begin
                    eif = 1'b1;
                    last_if = e.data;
                end
            end
            chk("if_rvalid", bus.if_rvalid_o, eif);
            chk("ls_rvalid", bus.ls_rvalid_o, els);
            chk("if_rdata", bus.if_rdata_o, last_if);
            chk("ls_rdata", bus.ls_rdata_o, last_ls);
        end
    end

    task automatic drive(input bit ifr, input logic [31:0] ifa,
                         input bit lsr, input logic [31:0] lsa);
        bus.if_req_i  = ifr;
        bus.if_addr_i = ifa;
        bus.ls_req_i  = lsr;
        bus.ls_addr_i = lsa;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef ROM_ARB_RR_EN
        exp_tab = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`else
        exp_tab = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
`endif
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h40;
        bus.ls_req_i  = 1'b1;
        bus.ls_addr_i = 32'h80;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        in_reset = 1'b0;
        drive(0, 0, 0, 0);

        // Contest from a clean state
        for (int i = 0; i < 6; i++) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = 32'h100 + 32'(i * 4);
            bus.ls_req_i  = 1'b1;
            bus.ls_addr_i = 32'h200 + 32'(i * 4);
            @(negedge clk);
            #1;
            chk($sformatf("contest%0d", i),
                {bus.if_gnt_o, bus.ls_gnt_o}, exp_tab[i]);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0);

        drive(1, 32'h4, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 32'h0, 0, 0);
        drive(1, 32'h4, 0, 0);
        drive(1, 32'h8, 0, 0);
        drive(0, 0, 0, 0);

        // LS withdraws after two cycles of losing to IF
        drive(1, 32'h10, 1, 32'h300);
        drive(1, 32'h14, 1, 32'h300);
        for (int i = 0; i < 6; i++) drive(1, 32'h18 + 32'(i * 4), 0, 0);
        for (int i = 0; i < 7; i++) drive(1, 32'h40 + 32'(i * 4), 1, 32'h304);
        drive(0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom & 32'hFFFC,
                  $urandom_range(0, 9) < 6, $urandom & 32'hFFFC);
        end
        drive(0, 0, 0, 0);

        // Reset asserted while an LS response is being returned
        bus.if_req_i  = 1'b0;
        bus.ls_req_i  = 1'b1;
        bus.ls_addr_i = 32'h5A4;
        @(posedge clk);
        #1;
        bus.ls_req_i = 1'b0;
        in_reset = 1'b1;
        rst = 1'b0;
        q.delete();
        last_if = '0;
        last_ls = '0;
        m_wait = 0;
        m_last_ls = 1'b1;
        #1;
        chk("midrst_ls_rvalid", bus.ls_rvalid_o, 0);
        chk("midrst_ls_rdata", bus.ls_rdata_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        in_reset = 1'b0;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        for (int i = 0; i < 100; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom & 32'hFFFC,
                  $urandom_range(0, 1) == 1, $urandom & 32'hFFFC);
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
